// File: rtl/asm_endereco_atual_if.sv
// Bus between the control/button logic and the playback address generator.
// The master drives the seek buttons, enable and PCM byte; the slave returns
// the PCM address, the seconds offset for the display and the next-song pulse.
interface asm_endereco_atual_if #(
  parameter int ADDR_W = 22
);

  logic              count;
  logic              passa_10s;
  logic              volta_10s;
  logic              passa_30s;
  logic              volta_30s;
  logic [7:0]        current_value;
  logic [ADDR_W-1:0] endereco;
  logic signed [8:0] time_adder;
  logic              prox_musica;

  modport master (
    output count,
    output passa_10s,
    output volta_10s,
    output passa_30s,
    output volta_30s,
    output current_value,
    input  endereco,
    input  time_adder,
    input  prox_musica
  );

  modport slave (
    input  count,
    input  passa_10s,
    input  volta_10s,
    input  passa_30s,
    input  volta_30s,
    input  current_value,
    output endereco,
    output time_adder,
    output prox_musica
  );

endinterface

// File: rtl/asm_endereco_atual.sv
// Playback address generator for the music player.
// Advances the PCM read address while enabled, applies +/-10 s and +/-30 s
// seeks on button rising edges, and on the end-of-song byte (0) rewinds the
// address and pulses a next-song request. All outputs are registered.
module asm_endereco_atual #(
  parameter int ADDR_W          = 22,
  parameter int SAMPLES_PER_SEC = 16000
) (
  input  logic                 clk,
  input  logic                 reset,
  asm_endereco_atual_if.slave  bus
);

  // One extra bit so forward sums can be compared against the top address
  // without overflowing.
  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] JUMP_10  = AW1'(10 * SAMPLES_PER_SEC);
  localparam logic [ADDR_W:0] JUMP_30  = AW1'(30 * SAMPLES_PER_SEC);
  localparam logic [ADDR_W:0] MAX_ADDR = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [0:0] {
    ST_PLAY = 1'b0,
    ST_FIM  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_endereco;
  logic [ADDR_W-1:0] w_endereco_nxt;
  logic signed [8:0] r_time_adder;
  logic signed [8:0] w_time_adder_nxt;
  logic              r_prox_musica;
  logic              w_prox_musica_nxt;

  logic              r_p10_d;
  logic              r_v10_d;
  logic              r_p30_d;
  logic              r_v30_d;

  logic              w_ev_p10;
  logic              w_ev_v10;
  logic              w_ev_p30;
  logic              w_ev_v30;

  logic              w_has_ev;
  logic              w_fwd;
  logic [ADDR_W:0]   w_jump_amt;
  logic signed [8:0] w_jump_sec;
  logic [ADDR_W:0]   w_fwd_sum;
  logic [ADDR_W:0]   w_bwd_diff;
  logic              w_jump_ok;

  // Rising edges of the seek buttons; a held press fires only once.
  assign w_ev_p10 = bus.passa_10s & ~r_p10_d;
  assign w_ev_v10 = bus.volta_10s & ~r_v10_d;
  assign w_ev_p30 = bus.passa_30s & ~r_p30_d;
  assign w_ev_v30 = bus.volta_30s & ~r_v30_d;

  assign w_fwd_sum  = {1'b0, r_endereco} + w_jump_amt;
  assign w_bwd_diff = {1'b0, r_endereco} - w_jump_amt;

  // Pick the single highest-priority seek event of this cycle.
  always_comb begin
    w_has_ev   = 1'b0;
    w_fwd      = 1'b0;
    w_jump_amt = '0;
    w_jump_sec = 9'sd0;
    if (w_ev_p30) begin
      w_has_ev   = 1'b1;
      w_fwd      = 1'b1;
      w_jump_amt = JUMP_30;
      w_jump_sec = 9'sd30;
    end else if (w_ev_v30) begin
      w_has_ev   = 1'b1;
      w_fwd      = 1'b0;
      w_jump_amt = JUMP_30;
      w_jump_sec = -9'sd30;
    end else if (w_ev_p10) begin
      w_has_ev   = 1'b1;
      w_fwd      = 1'b1;
      w_jump_amt = JUMP_10;
      w_jump_sec = 9'sd10;
    end else if (w_ev_v10) begin
      w_has_ev   = 1'b1;
      w_fwd      = 1'b0;
      w_jump_amt = JUMP_10;
      w_jump_sec = -9'sd10;
    end else begin
      w_has_ev   = 1'b0;
    end
  end

  // A jump is only taken if it stays inside the address space; out-of-range
  // seeks are refused rather than clamped.
  always_comb begin
    w_jump_ok = 1'b0;
    if (w_fwd) begin
      w_jump_ok = (w_fwd_sum <= MAX_ADDR);
    end else begin
      w_jump_ok = ({1'b0, r_endereco} >= w_jump_amt);
    end
  end

  // Next state and next output values of the playback FSM.
  always_comb begin
    w_state_nxt       = r_state;
    w_endereco_nxt    = r_endereco;
    w_time_adder_nxt  = 9'sd0;
    w_prox_musica_nxt = 1'b0;
    case (r_state)
      ST_PLAY: begin
        if (bus.current_value == 8'd0) begin
          w_endereco_nxt    = '0;
          w_prox_musica_nxt = 1'b1;
          w_state_nxt       = ST_FIM;
        end else if (w_has_ev) begin
          // The count increment is dropped in any seek cycle.
          if (w_jump_ok) begin
            if (w_fwd) begin
              w_endereco_nxt = w_fwd_sum[ADDR_W-1:0];
            end else begin
              w_endereco_nxt = w_bwd_diff[ADDR_W-1:0];
            end
            w_time_adder_nxt = w_jump_sec;
          end else begin
            w_endereco_nxt = r_endereco;
          end
        end else if (bus.count) begin
          w_endereco_nxt = r_endereco + ADDR_W'(1);
        end else begin
          w_endereco_nxt = r_endereco;
        end
      end
      ST_FIM: begin
        w_endereco_nxt = '0;
        if (bus.current_value != 8'd0) begin
          w_state_nxt = ST_PLAY;
        end else begin
          w_state_nxt = ST_FIM;
        end
      end
      default: begin
        w_endereco_nxt = '0;
        w_state_nxt    = ST_PLAY;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_PLAY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Button history for edge detection; keeps updating in every state so a
  // press made while waiting at the end marker never fires later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_p10_d <= 1'b0;
      r_v10_d <= 1'b0;
      r_p30_d <= 1'b0;
      r_v30_d <= 1'b0;
    end else begin
      r_p10_d <= bus.passa_10s;
      r_v10_d <= bus.volta_10s;
      r_p30_d <= bus.passa_30s;
      r_v30_d <= bus.volta_30s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_endereco    <= '0;
      r_time_adder  <= 9'sd0;
      r_prox_musica <= 1'b0;
    end else begin
      r_endereco    <= w_endereco_nxt;
      r_time_adder  <= w_time_adder_nxt;
      r_prox_musica <= w_prox_musica_nxt;
    end
  end

  assign bus.endereco    = r_endereco;
  assign bus.time_adder  = r_time_adder;
  assign bus.prox_musica = r_prox_musica;

endmodule

// File: tb/tb_asm_endereco_atual.sv
// Self-checking bench for asm_endereco_atual: directed scenarios followed by
// random stimulus, every cycle compared against a behavioural model.
module tb_asm_endereco_atual;

  localparam int AW   = 8;
  localparam int SPS  = 4;
  localparam int MAXA = (1 << AW) - 1;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  int   n_fail;

  // Model state: address as a plain integer, end-marker wait flag,
  // previous button levels {p30, v30, p10, v10}.
  int       m_addr;
  bit       m_fim;
  bit [3:0] m_prev;
  int       m_ta;
  bit       m_px;
  int       sec_of [4];

  asm_endereco_atual_if #(.ADDR_W(AW)) bus ();

  asm_endereco_atual #(
    .ADDR_W          (AW),
    .SAMPLES_PER_SEC (SPS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Predict the outputs after the coming clock edge from the current inputs.
  task automatic model_step();
    bit [3:0] lvl;
    bit [3:0] ev;
    int       idx;
    int       nxt;
    lvl  = {bus.passa_30s, bus.volta_30s, bus.passa_10s, bus.volta_10s};
    m_ta = 0;
    m_px = 1'b0;
    if (!reset) begin
      m_addr = 0;
      m_fim  = 1'b0;
      m_prev = 4'b0000;
      return;
    end
    ev     = lvl & ~m_prev;
    m_prev = lvl;
    if (m_fim) begin
      m_addr = 0;
      m_fim  = (bus.current_value == 8'd0);
    end else if (bus.current_value == 8'd0) begin
      m_addr = 0;
      m_px   = 1'b1;
      m_fim  = 1'b1;
    end else begin
      idx = -1;
      for (int k = 3; k >= 0; k--) begin
        if (ev[k] && idx < 0) idx = k;
      end
      if (idx >= 0) begin
        nxt = m_addr + sec_of[idx] * SPS;
        if (nxt >= 0 && nxt <= MAXA) begin
          m_addr = nxt;
          m_ta   = sec_of[idx];
        end
      end else if (bus.count) begin
        m_addr = (m_addr + 1) % (MAXA + 1);
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("endereco",    bus.endereco,    m_addr);
    chk("time_adder",  bus.time_adder,  m_ta);
    chk("prox_musica", bus.prox_musica, m_px);
  endtask

  task automatic set_btn(input bit p30, input bit v30, input bit p10, input bit v10);
    bus.passa_30s = p30;
    bus.volta_30s = v30;
    bus.passa_10s = p10;
    bus.volta_10s = v10;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    m_addr  = 0;
    m_fim   = 1'b0;
    m_prev  = 4'b0000;
    m_ta    = 0;
    m_px    = 1'b0;
    sec_of[3] = 30;
    sec_of[2] = -30;
    sec_of[1] = 10;
    sec_of[0] = -10;

    reset = 1'b0;
    bus.count = 1'b0;
    bus.current_value = 8'd11;
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset, then plain counting.
    step();
    step();
    chk("reset_addr", bus.endereco, 0);
    reset = 1'b1;
    bus.count = 1'b1;
    repeat (5) step();
    chk("count_5", bus.endereco, 5);
    repeat (95) step();
    chk("at_100", bus.endereco, 100);

    // Held forward press gives a single +10 s jump.
    bus.passa_10s = 1'b1;
    step();
    chk("fwd10_addr", bus.endereco, 140);
    chk("fwd10_ta", bus.time_adder, 10);
    repeat (9) step();
    chk("fwd10_held", bus.endereco, 149);
    chk("fwd10_once", bus.time_adder, 0);
    bus.passa_10s = 1'b0;
    step();
    bus.volta_10s = 1'b1;
    step();
    chk("bwd10_addr", bus.endereco, 110);
    chk("bwd10_ta", bus.time_adder, -10);
    bus.volta_10s = 1'b0;

    // Pause, resume, reset mid-playback.
    bus.count = 1'b0;
    repeat (50) step();
    chk("paused", bus.endereco, 110);
    bus.count = 1'b1;
    step();
    chk("resumed", bus.endereco, 111);
    reset = 1'b0;
    step();
    chk("mid_reset", bus.endereco, 0);
    step();
    reset = 1'b1;

    // Backward guard and 30 s jumps (paused so addresses stay exact).
    bus.count = 1'b0;
    bus.volta_10s = 1'b1;
    step();
    chk("bwd_guard", bus.endereco, 0);
    chk("bwd_guard_ta", bus.time_adder, 0);
    bus.volta_10s = 1'b0;
    step();
    bus.passa_30s = 1'b1;
    step();
    chk("fwd30", bus.endereco, 120);
    chk("fwd30_ta", bus.time_adder, 30);
    bus.passa_30s = 1'b0;
    step();
    bus.volta_30s = 1'b1;
    step();
    chk("bwd30", bus.endereco, 0);
    chk("bwd30_ta", bus.time_adder, -30);
    bus.volta_30s = 1'b0;
    step();
    bus.volta_30s = 1'b1;
    step();
    chk("bwd30_guard", bus.time_adder, 0);
    bus.volta_30s = 1'b0;

    // End-of-song marker, with a press made while waiting.
    bus.count = 1'b1;
    repeat (3) step();
    bus.current_value = 8'd0;
    step();
    chk("eos_addr", bus.endereco, 0);
    chk("eos_pulse", bus.prox_musica, 1);
    bus.passa_30s = 1'b1;
    step();
    chk("eos_one_pulse", bus.prox_musica, 0);
    bus.current_value = 8'd11;
    step();
    chk("fim_hold", bus.endereco, 0);
    step();
    chk("restart", bus.endereco, 1);
    chk("no_fim_press", bus.time_adder, 0);
    bus.passa_30s = 1'b0;
    step();

    // Simultaneous presses and jump coincident with count.
    set_btn(1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk("prio_addr", bus.endereco, 122);
    chk("prio_ta", bus.time_adder, 30);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);

    // Forward guard at the top and wrap to zero.
    for (int i = 0; i < 300 && m_addr != MAXA; i++) step();
    chk("top", bus.endereco, MAXA);
    bus.passa_10s = 1'b1;
    step();
    chk("fwd_guard", bus.endereco, MAXA);
    chk("fwd_guard_ta", bus.time_adder, 0);
    bus.passa_10s = 1'b0;
    step();
    chk("wrap", bus.endereco, 0);

    // Random stimulus against the model.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      bus.count = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) bus.passa_30s = ~bus.passa_30s;
      if ($urandom_range(0, 7) == 0) bus.volta_30s = ~bus.volta_30s;
      if ($urandom_range(0, 5) == 0) bus.passa_10s = ~bus.passa_10s;
      if ($urandom_range(0, 5) == 0) bus.volta_10s = ~bus.volta_10s;
      bus.current_value = ($urandom_range(0, 29) == 0) ? 8'd0
                          : 8'($urandom_range(1, 255));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/asm_endereco_atual.md
Name: asm_endereco_atual

Overview:
Playback address generator (ASM) for the music player.
- Advances the PCM memory read address while playback is enabled.
- Applies ±10 s and ±30 s seek jumps from debounced button inputs.
- Detects the end-of-song marker (PCM value 0), rewinds the address and requests the next song.
- Sits between the control/button logic and the PCM memory; feeds a seconds offset to the elapsed-time display.

Parameters:
- ADDR_W, 22, width of endereco.
- SAMPLES_PER_SEC, 16000, address increments per second of audio; a jump of N s moves the address by N*SAMPLES_PER_SEC.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- count  input  1  advance enable; 1 = advance address by 1 this cycle, 0 = pause.
- passa_10s  input  1  seek forward 10 s, level input, rising-edge detected.
- volta_10s  input  1  seek back 10 s, rising-edge detected.
- passa_30s  input  1  seek forward 30 s, rising-edge detected.
- volta_30s  input  1  seek back 30 s, rising-edge detected.
- current_value  input  8  PCM byte currently read at endereco; 0 = end-of-song marker.
- endereco  output  ADDR_W  current PCM address, registered.
- time_adder  output  9 signed  seconds delta of a jump applied this cycle (+10, -10, +30, -30), else 0.
- prox_musica  output  1  one-cycle pulse requesting next song.

Behaviour:
- Reset (reset==0 at a clk edge):
  - endereco=0, time_adder=0, prox_musica=0.
  - Edge-detect registers cleared to 0; state=PLAY.
  - Reset dominates all other inputs.
- Edge detection: each seek input registered once; event = input & ~input_d. A press held for many cycles yields exactly one jump.
- States:
  - PLAY: normal operation.
  - FIM: end marker seen, waiting for current_value != 0.
- PLAY, evaluated in this priority order each cycle:
  1. current_value==0: endereco<=0, prox_musica=1 for this one cycle, time_adder=0, go to FIM.
  2. Seek event; if several arrive in the same cycle, priority is passa_30s > volta_30s > passa_10s > volta_10s, and only one jump is applied.
     - Forward: if endereco + N*SAMPLES_PER_SEC <= 2^ADDR_W-1, add it and time_adder=+N for one cycle. Otherwise no change and time_adder=0.
     - Backward: if endereco >= N*SAMPLES_PER_SEC, subtract it and time_adder=-N for one cycle. Otherwise no change and time_adder=0 (no clamping).
     - The count increment is dropped in a jump cycle.
     - Jumps are honoured even when count==0.
  3. Otherwise, if count==1: endereco<=endereco+1, wrapping at 2^ADDR_W-1 to 0. If count==0: hold.
- FIM:
  - endereco held at 0, prox_musica=0, time_adder=0.
  - Seek events and count ignored; edge registers still update, so a press made in FIM does not fire later.
  - current_value!=0 → PLAY next cycle.
- Outputs are all registered: one-cycle latency from input to output change.
- time_adder and prox_musica are 0 in every cycle without their event.

Test Plan:
1. SAMPLES_PER_SEC=4, reset=0 for 2 cycles, then reset=1, count=1, current_value=11 → endereco 0 after reset, then increments by 1 per clk.
2. Seek forward at endereco=100:
   - passa_10s held high for 10 cycles → single jump to 100+40 (+1 on subsequent counts), time_adder=+10 for exactly one cycle.
   - volta_10s then returns the address by 40 with time_adder=-10.
3. count=0 for 50 cycles → endereco frozen; count=1 → resumes from the same value. Apply reset=0 mid-playback → endereco=0 on the next edge, held until reset=1.
4. Backward-jump guard at endereco<40 after reset: volta_10s → no change, time_adder stays 0. Then passa_30s → +120 with time_adder=+30, volta_30s → -120 with time_adder=-30, a second volta_30s → no change.
5. current_value=0 during PLAY → endereco=0 and prox_musica=1 for one cycle, then address stays 0 while the value remains 0. current_value=11 → counting restarts from 0, and no second prox_musica pulse.
6. passa_30s and volta_10s rising in the same cycle → only +30 s applied. A jump coincident with count=1 → no extra +1 that cycle.
